// File: rtl/div32_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock with a start/done handshake.
// Results are registered and held until the next done pulse.
module div32_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;
  localparam logic [1:0] StDz   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmdr_q, rmdr_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    count_d   = count_q;
    quot_d    = quot_q;
    rmdr_d    = rmdr_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    // rem < divisor, so the shifted value is < 2*divisor and the sign lands in trial[WIDTH].
    trial     = rem_shift - {1'b0, dvs_q};

    case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d   = a;
          dvs_d   = b;
          rem_d   = '0;
          count_d = '0;
          state_d = (b == '0) ? StDz : StCalc;
        end
      end
      StCalc: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == LastCount) begin
          state_d = StFin;
        end
      end
      StFin: begin
        quot_d  = dvd_q;
        rmdr_d  = rem_q;
        dz_d    = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StDz: begin
        // Dividend was parked in the shift register; report it as the remainder.
        quot_d  = '1;
        rmdr_d  = dvd_q;
        dz_d    = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rmdr_q  <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rmdr_q  <= rmdr_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rmdr_q;
  assign busy        = (state_q == StCalc);
  assign done        = done_q;
  assign div_by_zero = dz_q;

endmodule
